// File: rtl/ft8_encoder_scheduler_pkg.sv
// Shared types and widths for the FT8 encoder scheduler.
package ft8_pkg;
  localparam int MSG_BITS    = 72;
  localparam int PACKED_BITS = 87;
  localparam int NUM_SRC     = 2;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    TRIGGER,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/ft8_encoder_scheduler_arbiter.sv
// Two-way round-robin arbiter; ties go to the source not served last.
module ft8_rr_arbiter
  import ft8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant
);

  // 1 means source 1 was served last, so source 0 wins the next tie
  logic last_src;

  always_comb begin
    grant = '0;
    if (en) begin
      if (req == 2'b11) grant = last_src ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               last_src <= 1'b1;
    else if (grant != '0)  last_src <= grant[1];
  end

endmodule

// File: rtl/ft8_encoder_scheduler.sv
// Arbitrates two message sources onto the packed-message encoder, streams
// the 9 message bytes plus a packing strobe, and returns the tagged result.
//
// state   | meaning
// IDLE    | waiting for tx_enable and a request; grant pulses here
// SEND    | strobe the next message byte when enc_ready
// GAP     | valid held low until enc_ready; encoder re-arms on low valid
// TRIGGER | strobe 0x00 to start packing
// WAIT    | waiting for enc_packed_valid, bounded by the result timer
// DONE    | result_valid pulse
module ft8_encoder_scheduler
  import ft8_pkg::*;
#(
  parameter int NUM_BYTES      = 9,
  parameter int RESULT_TIMEOUT = 16,
  parameter int READY_TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_enable,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [MSG_BITS-1:0]    msg0,
  input  logic [MSG_BITS-1:0]    msg1,
  output logic [NUM_SRC-1:0]     grant,
  output logic [7:0]             enc_ascii,
  output logic                   enc_data_valid,
  input  logic                   enc_ready,
  input  logic [PACKED_BITS-1:0] enc_packed_msg,
  input  logic                   enc_packed_valid,
  output logic [PACKED_BITS-1:0] result_msg,
  output logic                   result_src,
  output logic                   result_valid,
  output logic                   error,
  output logic                   busy
);

  localparam int TMR_MAX = (RESULT_TIMEOUT > READY_TIMEOUT) ? RESULT_TIMEOUT : READY_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(NUM_BYTES + 1);

  state_t              state, state_nxt;
  logic [MSG_BITS-1:0] shreg;
  logic [CNT_W-1:0]    byte_cnt;
  logic [TMR_W-1:0]    tmr;
  logic                src_q;
  logic                shift_en;
  logic                capture;

  ft8_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    ((state == IDLE) && tx_enable),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    state_nxt      = state;
    enc_ascii      = 8'h00;
    enc_data_valid = 1'b0;
    result_valid   = 1'b0;
    error          = 1'b0;
    shift_en       = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: if (grant != '0) state_nxt = SEND;
      SEND: begin
        if (enc_ready) begin
          enc_data_valid = 1'b1;
          enc_ascii      = shreg[MSG_BITS-1 -: 8];
          shift_en       = 1'b1;
          state_nxt      = GAP;
        end else if (tmr == '0) begin
          error     = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (enc_ready) begin
          state_nxt = (byte_cnt < CNT_W'(NUM_BYTES)) ? SEND : TRIGGER;
        end else if (tmr == '0) begin
          error     = 1'b1;
          state_nxt = IDLE;
        end
      end
      TRIGGER: begin
        if (enc_ready) begin
          enc_data_valid = 1'b1;
          state_nxt      = WAIT;
        end else if (tmr == '0) begin
          error     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (enc_packed_valid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (tmr == '0) begin
          error     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      tmr        <= '0;
      src_q      <= 1'b0;
      result_msg <= '0;
      result_src <= 1'b0;
    end else begin
      state <= state_nxt;
      // every state entry restarts the down-counter; terminal count is zero
      if (state_nxt != state)
        tmr <= (state_nxt == WAIT) ? TMR_W'(RESULT_TIMEOUT) : TMR_W'(READY_TIMEOUT);
      else if (tmr != '0)
        tmr <= tmr - 1'b1;
      if (grant != '0) begin
        shreg    <= grant[1] ? msg1 : msg0;
        byte_cnt <= '0;
        src_q    <= grant[1];
      end else if (shift_en) begin
        shreg    <= shreg << 8;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (capture) begin
        result_msg <= enc_packed_msg;
        result_src <= src_q;
      end
    end
  end

endmodule

// File: tb/tb_ft8_encoder_scheduler.sv
// Scoreboard bench for ft8_encoder_scheduler with a simple encoder model.
module tb_ft8_encoder_scheduler;

  logic        clk, rst, tx_enable;
  logic [1:0]  req;
  logic [71:0] msg0, msg1;
  logic [1:0]  grant;
  logic [7:0]  enc_ascii;
  logic        enc_data_valid, enc_ready;
  logic [86:0] enc_packed_msg;
  logic        enc_packed_valid;
  logic [86:0] result_msg;
  logic        result_src, result_valid, error, busy;

  ft8_encoder_scheduler dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .req(req),
    .msg0(msg0), .msg1(msg1), .grant(grant),
    .enc_ascii(enc_ascii), .enc_data_valid(enc_data_valid), .enc_ready(enc_ready),
    .enc_packed_msg(enc_packed_msg), .enc_packed_valid(enc_packed_valid),
    .result_msg(result_msg), .result_src(result_src), .result_valid(result_valid),
    .error(error), .busy(busy)
  );

  localparam logic [71:0] MA = 72'h11_22_33_44_55_66_77_88_99;
  localparam logic [71:0] MB = 72'hA1_B2_C3_D4_E5_F6_07_18_29;
  localparam logic [71:0] MC = 72'h00_FF_00_FF_00_FF_00_FF_00;
  localparam logic [71:0] MD = 72'hFF_00_FF_00_FF_00_FF_00_FF;
  localparam logic [71:0] M0 = 72'h41_42_43_44_45_46_47_48_49;
  localparam logic [71:0] ME = 72'h53_54_41_4C_4C_5F_54_45_53;
  localparam logic [71:0] MF = 72'hDE_AD_BE_EF_01_23_45_67_89;
  localparam logic [71:0] MG = 72'h43_51_20_4B_31_41_42_43_44;
  localparam logic [71:0] MH = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] MI = 72'h90_80_70_60_50_40_30_20_10;

  int n_vec = 0, n_bad = 0, cyc = 0;

  logic [1:0]  exp_grant[$];
  logic [7:0]  exp_byte[$];
  logic [87:0] exp_res[$];
  bit          exp_err[$];

  // encoder model state
  int          nbytes = 0, stall_cnt = 0, stall_at = 0, trig_cyc = 0;
  bit          stall_done = 0, suppress = 0, spur = 0;
  logic [71:0] rx;
  logic [86:0] pval;
  logic        pv_next;

  // monitor state
  int          grant_cyc = 0;
  bit          first_strobe = 0, busy_chk = 0;
  logic        prev_v = 0;
  logic [87:0] e_res;

  function automatic logic [86:0] pack(input logic [71:0] m);
    return {m, m[71:57] ^ 15'h2a5b};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [1:0] g, input logic [71:0] m, input int nb, input bit tmo);
    exp_grant.push_back(g);
    for (int i = 0; i < nb; i++) exp_byte.push_back(m[71-8*i -: 8]);
    if (nb == 9) begin
      exp_byte.push_back(8'h00);
      if (tmo) exp_err.push_back(1'b1);
      else     exp_res.push_back({pack(m), g[1]});
    end
  endtask

  task automatic wait_grant(input int b);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (grant[b]) got = 1;
    end
    chk("grant_timeout", 128'(got), 128'(1));
    step();
    req[b] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("idle_timeout", 128'(done), 128'(1));
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"},  128'(grant), 128'(0));
    chk({tag, "_ascii"},  128'(enc_ascii), 128'(0));
    chk({tag, "_valid"},  128'(enc_data_valid), 128'(0));
    chk({tag, "_rmsg"},   128'(result_msg), 128'(0));
    chk({tag, "_rsrc"},   128'(result_src), 128'(0));
    chk({tag, "_rvalid"}, 128'(result_valid), 128'(0));
    chk({tag, "_error"},  128'(error), 128'(0));
    chk({tag, "_busy"},   128'(busy), 128'(0));
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // encoder model: collects bytes, answers the packing strobe one cycle later
  initial begin
    enc_ready = 1'b1;
    enc_packed_valid = 1'b0;
    enc_packed_msg = '0;
    rx = '0;
    pval = '0;
    forever begin
      @(negedge clk);
      pv_next = 1'b0;
      if (rst) begin
        nbytes = 0;
        stall_cnt = 0;
      end else if (enc_data_valid) begin
        if (nbytes == 9) begin
          trig_cyc = cyc;
          nbytes = 0;
          pv_next = !suppress;
          pval = pack(rx);
        end else begin
          rx = {rx[63:0], enc_ascii};
          nbytes++;
          if (stall_at != 0 && nbytes == stall_at - 1 && !stall_done) begin
            stall_cnt = 5;
            stall_done = 1;
          end
          if (spur && nbytes == 4) begin
            pv_next = 1'b1;
            pval = {87{1'b1}};
          end
        end
      end
      @(posedge clk);
      #1;
      enc_packed_valid = pv_next;
      enc_packed_msg = pv_next ? pval : 87'h0;
      if (stall_cnt > 0) begin
        enc_ready = 1'b0;
        stall_cnt--;
      end else begin
        enc_ready = 1'b1;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an output
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (busy_chk) begin
        chk("busy_after_error", 128'(busy), 128'(0));
        busy_chk = 0;
      end
      if (grant != 2'b00) begin
        if (exp_grant.size() == 0) unexpected("grant_unexpected");
        else chk("grant", 128'(grant), 128'(exp_grant.pop_front()));
        grant_cyc = cyc;
        first_strobe = 1;
      end
      if (enc_data_valid) begin
        chk("valid_gap", 128'(prev_v), 128'(0));
        chk("valid_ready", 128'(enc_ready), 128'(1));
        if (exp_byte.size() == 0) unexpected("byte_unexpected");
        else chk("byte", 128'(enc_ascii), 128'(exp_byte.pop_front()));
        if (first_strobe) chk("grant_to_strobe", 128'(cyc - grant_cyc), 128'(1));
        first_strobe = 0;
      end
      prev_v = enc_data_valid;
      if (result_valid) begin
        chk("result_overlap", 128'({grant, error}), 128'(0));
        chk("result_latency", 128'(cyc - trig_cyc), 128'(2));
        if (exp_res.size() == 0) unexpected("result_unexpected");
        else begin
          e_res = exp_res.pop_front();
          chk("result_msg", 128'(result_msg), 128'(e_res[87:1]));
          chk("result_src", 128'(result_src), 128'(e_res[0]));
        end
      end
      if (error) begin
        if (exp_err.size() == 0) unexpected("error_unexpected");
        else begin
          void'(exp_err.pop_front());
          chk("error_latency", 128'(cyc - trig_cyc), 128'(17));
          busy_chk = 1;
        end
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    int ns;
    rst = 1'b1;
    tx_enable = 1'b1;
    req = 2'b00;
    msg0 = '0;
    msg1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    step();
    rst = 1'b0;
    step();

    // contention twice: source 0 first each round, then source 1
    msg0 = MA; msg1 = MB;
    push_job(2'b01, MA, 9, 0);
    push_job(2'b10, MB, 9, 0);
    req = 2'b11;
    wait_grant(0);
    wait_grant(1);
    wait_idle();
    msg0 = MC; msg1 = MD;
    push_job(2'b01, MC, 9, 0);
    push_job(2'b10, MD, 9, 0);
    req = 2'b11;
    wait_grant(0);
    wait_grant(1);
    wait_idle();

    // single request, with a stray enc_packed_valid mid-stream
    spur = 1;
    msg0 = M0;
    push_job(2'b01, M0, 9, 0);
    req = 2'b01;
    wait_grant(0);
    wait_idle();
    spur = 0;

    // ready stall before byte 3 on source 1
    stall_at = 3; stall_done = 0;
    msg1 = ME;
    push_job(2'b10, ME, 9, 0);
    req = 2'b10;
    wait_grant(1);
    wait_idle();
    chk("stall_applied", 128'(stall_done), 128'(1));
    stall_at = 0; stall_done = 0;

    // result timeout
    suppress = 1;
    msg0 = MF;
    push_job(2'b01, MF, 9, 1);
    req = 2'b01;
    wait_grant(0);
    wait_idle();
    suppress = 0;

    // tx_enable gating, then drop it mid-job
    tx_enable = 1'b0;
    msg0 = MG;
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("txen_hold", 128'({grant, busy}), 128'(0));
    end
    push_job(2'b01, MG, 9, 0);
    step();
    tx_enable = 1'b1;
    @(negedge clk);
    chk("txen_grant", 128'(grant), 128'(2'b01));
    step();
    req = 2'b00;
    repeat (6) step();
    tx_enable = 1'b0;
    wait_idle();
    tx_enable = 1'b1;

    // reset during byte 5, then restart
    msg0 = MH;
    push_job(2'b01, MH, 5, 0);
    req = 2'b01;
    wait_grant(0);
    ns = 0;
    for (int i = 0; i < 100 && ns < 5; i++) begin
      @(negedge clk);
      if (enc_data_valid) ns++;
    end
    chk("rst_strobes", 128'(ns), 128'(5));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    step();
    msg0 = MI;
    push_job(2'b01, MI, 9, 0);
    req = 2'b01;
    wait_grant(0);
    wait_idle();

    repeat (4) step();
    chk("left_grant", 128'(exp_grant.size()), 128'(0));
    chk("left_byte",  128'(exp_byte.size()), 128'(0));
    chk("left_res",   128'(exp_res.size()), 128'(0));
    chk("left_err",   128'(exp_err.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
